gpr_wb_arbiter: RTL and testbench
=================================

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter: CNT_W, default 2, width of each per-register pending-write counter (max pending = 2^CNT_W-1).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk in 1 (rising-edge clock); reset in 1 (asynchronous, active-low).
REQ-003 Ports SHALL be:
- iss_valid in 1: issue stage claims a destination.
- iss_rd in 5: claimed destination register.
- iss_ready out 1: claim accepted.
- alu_valid in 1 / alu_rd in 5 / alu_data in 32 / alu_ready out 1: execute writeback request.
- mem_valid in 1 / mem_rd in 5 / mem_data in 32 / mem_ready out 1: load writeback request.
- regWr out 1 / Rw out 5 / busW out 32: register file write port.
- busy out 32: bit i high when register i has a nonzero pending count.

Function
REQ-004 A writeback transfer SHALL occur on a requester when its valid and ready are both high at a rising clk edge.
REQ-005 At most one writeback transfer SHALL occur per cycle; the grant SHALL be combinational, and ready is high only for the granted requester.
- Ready SHALL NOT depend on the non-granted requester's ready.
REQ-006 A transfer SHALL drive regWr=1, Rw=rd and busW=data on the next cycle (1-cycle latency).
- When no transfer occurs, regWr SHALL be 0 and Rw/busW SHALL hold their previous values.
REQ-007 A transfer with rd=0 SHALL be accepted, but SHALL produce regWr=0 and SHALL NOT change any counter.
REQ-008 The block SHALL keep one CNT_W-bit pending counter per register 1..31; register 0's counter SHALL be constant 0.
REQ-009 iss_ready SHALL be 0 when counter[iss_rd] is at maximum, and 1 otherwise.
- A claim with iss_rd=0 SHALL always be ready and SHALL have no effect.
REQ-010 An accepted claim SHALL increment counter[iss_rd]; a writeback transfer SHALL decrement counter[rd].
- If both target the same register in the same cycle, the counter SHALL be unchanged.
REQ-011 A writeback transfer to a register whose counter is 0 SHALL leave the counter at 0 (no underflow) and SHALL still write the register file.
REQ-012 busy SHALL be derived combinationally from the counters.
- Increments and decrements are visible on busy the cycle after the transfer.
REQ-013 An accepted claim at maximum SHALL be impossible by construction, so counters SHALL never wrap.

Reset
REQ-014 Asserting reset at any time, including mid-transfer, SHALL immediately force:
- all counters to 0;
- regWr=0, Rw=0, busW=0, busy=0;
- the round-robin pointer to favour mem.
REQ-015 While reset is low, all ready outputs SHALL be 0 and no transfer SHALL occur; deassertion SHALL take effect at the first rising clk edge after release.

Configuration
REQ-016 Macro GPR_WB_RR_EN defined: arbitration SHALL be round-robin.
- The requester not granted in the last transfer cycle wins a tie.
- The pointer updates only on cycles with a transfer.
REQ-017 GPR_WB_RR_EN undefined: arbitration SHALL be fixed priority, mem over alu, and no pointer state SHALL exist.

Verification
REQ-018 After reset release, claim rd=5 and then alu writeback rd=5 data=0xDEADBEEF -> busy[5] rises the cycle after the claim; the next cycle after the transfer gives regWr=1, Rw=5, busW=0xDEADBEEF; busy[5] falls the same cycle.
REQ-019 alu and mem both valid for 4 cycles with rd=1 and rd=2 -> with GPR_WB_RR_EN: grants mem, alu, mem, alu. Without GPR_WB_RR_EN: mem, then alu only after mem_valid drops.
REQ-020 Claim rd=7 three times with CNT_W=2 -> iss_ready=0 on the fourth claim. A simultaneous claim plus writeback rd=7 leaves the count at 3, and iss_ready stays 0.
REQ-021 mem writeback rd=0 data=0x1 -> mem_ready=1; the next cycle regWr=0; busy stays 0.
REQ-022 Writeback rd=9 with no prior claim -> regWr=1, Rw=9; counter[9] stays 0; busy[9]=0.
REQ-023 reset asserted low in the same cycle as a grant -> regWr=0, busy=0 immediately; after release, a new claim rd=3 sets busy[3] normally.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: one register-file write port shared by alu and mem, plus pending-write scoreboard.
// Define GPR_WB_RR_EN for round-robin arbitration; otherwise mem has fixed priority over alu.
module gpr_wb_arbiter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        regWr,
    output logic [4:0]  Rw,
    output logic [31:0] busW,
    output logic [31:0] busy
);
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned DW   = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic [CNT_W-1:0] cnt_c [0:NREG-1];
    logic             regwr_q;
    logic [RW-1:0]    rw_q;
    logic [DW-1:0]    busw_q;
    logic             fav_mem_c;
    logic             mem_gnt_c;
    logic             alu_gnt_c;
    logic             wb_xfer_c;
    logic [RW-1:0]    wb_rd_c;
    logic [DW-1:0]    wb_data_c;
    logic [NREG-1:0]  claim_vec_c;
    logic [NREG-1:0]  wb_vec_c;

`ifdef GPR_WB_RR_EN
    // Set when mem wins a tie: the requester that lost the last transfer.
    logic fav_mem_q;
    assign fav_mem_c = fav_mem_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fav_mem_q <= 1'b1;
        end else if (wb_xfer_c) begin
            fav_mem_q <= alu_gnt_c;
        end
    end
`else
    assign fav_mem_c = 1'b1;
`endif

    always_comb begin
        mem_gnt_c = reset & mem_valid & (fav_mem_c | ~alu_valid);
        alu_gnt_c = reset & alu_valid & ~mem_gnt_c;
        wb_xfer_c = mem_gnt_c | alu_gnt_c;
        wb_rd_c   = mem_gnt_c ? mem_rd : alu_rd;
        wb_data_c = mem_gnt_c ? mem_data : alu_data;
    end

    assign mem_ready = mem_gnt_c;
    assign alu_ready = alu_gnt_c;

    always_comb begin
        cnt_c[0] = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            cnt_c[i] = cnt_q[i];
        end
    end

    assign iss_ready = reset & ((iss_rd == '0) | (cnt_c[iss_rd] != CNT_MAX));

    // A claim and a writeback on the same register cancel, even if the claim is stalled.
    always_comb begin
        claim_vec_c = (reset & iss_valid) ? (NREG'(1) << iss_rd) : '0;
        wb_vec_c    = wb_xfer_c ? (NREG'(1) << wb_rd_c) : '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (claim_vec_c[i] && wb_vec_c[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (claim_vec_c[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (wb_vec_c[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            busy[i] = |cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            regwr_q <= 1'b0;
            rw_q    <= '0;
            busw_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            regwr_q <= wb_xfer_c & (wb_rd_c != '0);
            if (wb_xfer_c) begin
                rw_q   <= wb_rd_c;
                busw_q <= wb_data_c;
            end
        end
    end

    assign regWr = regwr_q;
    assign Rw    = rw_q;
    assign busW  = busw_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: per-cycle scoreboard model plus directed literal checks.
module tb_gpr_wb_arbiter;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef GPR_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        iss_ready;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        regWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [31:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    gpr_wb_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .regWr(regWr), .Rw(Rw), .busW(busW), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pending counts, last writeback, and which requester lost the last tie
    int          m_cnt [32];
    bit          m_regwr = 1'b0;
    logic [4:0]  m_rw = '0;
    logic [31:0] m_busw = '0;
    bit          m_last_alu = 1'b1;

    initial for (int i = 0; i < 32; i++) m_cnt[i] = 0;

    function automatic logic [1:0] exp_gnt();
        logic mem_wins_tie;
        if (!reset) return 2'b00;
        mem_wins_tie = RR ? m_last_alu : 1'b1;
        if (mem_valid && alu_valid) return mem_wins_tie ? 2'b10 : 2'b01;
        return {mem_valid, alu_valid};
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    logic [1:0]  u_g;
    int          u_rd;
    logic [31:0] u_dat;
    bit          u_claim;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_regwr = 0; m_rw = '0; m_busw = '0; m_last_alu = 1'b1;
        end else begin
            u_g = exp_gnt();
            u_rd = 0;
            u_dat = '0;
            if (u_g != 2'b00) begin
                u_rd  = u_g[1] ? int'(mem_rd) : int'(alu_rd);
                u_dat = u_g[1] ? mem_data : alu_data;
                m_regwr = (u_rd != 0);
                m_rw = 5'(u_rd);
                m_busw = u_dat;
                m_last_alu = u_g[0];
            end else begin
                m_regwr = 0;
            end
            u_claim = iss_valid && (iss_rd != 0);
            if (!(u_claim && u_g != 2'b00 && u_rd == int'(iss_rd))) begin
                if (u_claim && m_cnt[iss_rd] < MAXC) m_cnt[iss_rd]++;
                if (u_g != 2'b00 && u_rd != 0 && m_cnt[u_rd] > 0) m_cnt[u_rd]--;
            end
        end
    end

    logic [1:0] c_g;
    always @(negedge clk) begin
        c_g = exp_gnt();
        chk("mem_ready", 32'(mem_ready), 32'(c_g[1]));
        chk("alu_ready", 32'(alu_ready), 32'(c_g[0]));
        chk("iss_ready", 32'(iss_ready),
            32'(reset && (iss_rd == 0 || m_cnt[iss_rd] < MAXC)));
        chk("regWr", 32'(regWr), 32'(m_regwr));
        chk("Rw", 32'(Rw), 32'(m_rw));
        chk("busW", busW, m_busw);
        chk("busy", busy, exp_busy());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_mem_seq;

    initial begin
        // Reset held: readies blocked even with requests present
        mem_valid = 1'b1;
        #3;
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_regWr", 32'(regWr), 32'd0);
        #9;
        reset = 1'b1;
        mem_valid = 1'b0;

        // Claim rd5, then alu writes it back
        tick();
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("claim_busy5", 32'(busy[5]), 32'd1);
        chk("alu_ready5", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("wb5_regWr", 32'(regWr), 32'd1);
        chk("wb5_Rw", 32'(Rw), 32'd5);
        chk("wb5_busW", busW, 32'hDEADBEEF);
        chk("wb5_busy5", 32'(busy[5]), 32'd0);

        // Both requesters contend for four cycles
        exp_mem_seq = RR ? 4'b0101 : 4'b1111;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb_mem_gnt", 32'(mem_ready), 32'(exp_mem_seq[k]));
            chk("arb_alu_gnt", 32'(alu_ready), 32'(!exp_mem_seq[k]));
            tick();
        end
        mem_valid = 1'b0;
        #1;
        chk("arb_alu_after", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;

        // Saturate rd7, then a simultaneous claim and writeback
        iss_valid = 1'b1; iss_rd = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("claim7_ready", 32'(iss_ready), 32'd1);
            tick();
        end
        #1;
        chk("claim7_full", 32'(iss_ready), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        #1;
        chk("claim7_wb_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("claim7_still_full", 32'(iss_ready), 32'd0);
        chk("claim7_wb_Rw", 32'(Rw), 32'd7);
        iss_valid = 1'b0;
        alu_valid = 1'b1;
        tick(); tick(); tick();
        alu_valid = 1'b0;
        #1;
        chk("drain7_busy", busy, 32'd0);

        // Writeback to r0 alongside a claim of r0
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        chk("r0_mem_ready", 32'(mem_ready), 32'd1);
        chk("r0_iss_ready", 32'(iss_ready), 32'd1);
        tick();
        mem_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("r0_regWr", 32'(regWr), 32'd0);
        chk("r0_busy", busy, 32'd0);

        // Unclaimed writeback to rd9
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("r9_regWr", 32'(regWr), 32'd1);
        chk("r9_Rw", 32'(Rw), 32'd9);
        chk("r9_busy", busy, 32'd0);

        // Reset dropped during a granted cycle
        iss_valid = 1'b1; iss_rd = 5'd4;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h1010;
        tick();
        iss_valid = 1'b0; mem_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        #1;
        chk("pre_rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("pre_rst_busy", busy, 32'h10);
        chk("pre_rst_regWr", 32'(regWr), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_regWr", 32'(regWr), 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_Rw", 32'(Rw), 32'd0);
        chk("mid_rst_busW", busW, 32'd0);
        chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        #2;
        reset = 1'b1;
        alu_valid = 1'b0;
        tick();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("post_rst_busy3", busy, 32'h8);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
